// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative divide sequencer.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivSigned         = 1'b1;
  localparam logic DivUnsigned       = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, select.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W:0]   rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W+1:0] rem_sh;
  logic [DATA_W+1:0] diff;

  // Extra top bit turns the borrow into a plain sign test.
  assign rem_sh = {rem_i, quo_i[DATA_W-1]};
  assign diff   = rem_sh - {2'b00, dvs_i};

  always_comb begin
    if (!diff[DATA_W+1]) begin
      rem_o = diff[DATA_W:0];
    end else begin
      rem_o = rem_sh[DATA_W:0];
    end
    quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W+1]};
  end

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned divider, one quotient bit per cycle, with stall and flush.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W:0]       rem_q, rem_d, rem_nx;
  logic [DATA_W-1:0]     quo_q, quo_d, quo_nx;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic                  sa_q, sa_d, sb_q, sb_d, sg_q, sg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic [DATA_W-1:0]     op1_abs, op2_abs, quo_fix, rem_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  assign op1_abs = (signed_div_i == DivSigned && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i == DivSigned && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Fixup works on the final step output so the result lands on the last iteration edge.
  assign quo_fix = (sg_q == DivSigned && sa_q != sb_q) ? -quo_nx : quo_nx;
  assign rem_fix = (sg_q == DivSigned && sa_q) ? -rem_nx[DATA_W-1:0] : rem_nx[DATA_W-1:0];

  assign stall_req_o = start_i && !annul_i && (state_q != DIV_END);
  assign result_o    = result_q;
  assign ready_o     = ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sg_d     = sg_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      DIV_FREE: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = op1_abs;
            dvs_d   = op2_abs;
            sa_d    = opdata1_i[DATA_W-1];
            sb_d    = opdata2_i[DATA_W-1];
            sg_d    = signed_div_i;
          end
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = DivResultNotReady;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = DivResultNotReady;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            result_d = {rem_fix, quo_fix};
            ready_d  = DivResultReady;
            state_d  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (start_i == DivStop) begin
          state_d  = DIV_FREE;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else begin
          ready_d = DivResultReady;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      sg_q     <= DivUnsigned;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sg_q     <= sg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule
